alu_result_display: RTL and testbench

Consumer end of the ALU result path: captures an ALU result word and its `Error` flag, converts the binary value to three BCD digits with a sequential shift-add-3 (double-dabble) engine, and drives a 4-digit time-multiplexed seven-segment display. It sits between the ALU operation blocks (adder, subtractor, multiplier) and the board display pins, and is the only block that touches `Sseg`/`An`.

---
 rtl/alu_result_display.sv | 229 ++++++++++++++++++++++
 tb/tb_alu_result_display.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_display.sv
// alu_result_display
//   Captures an ALU result and its error flag, converts the binary value to
//   three BCD digits with a sequential double-dabble engine, and scans the
//   result onto a 4-digit, active-low, time-multiplexed seven-segment display.
//
// Parameters
//   W    result width in bits (1..9)
//   DIV  clocks per digit refresh slot (>= 2)
//
// Ports
//   Clock   in   system clock, rising edge
//   Reset   in   synchronous active-low reset
//   Init    in   result-valid strobe, sampled only while idle
//   Result  in   [W-1:0] unsigned ALU result
//   Error   in   ALU error flag, captured with Result
//   Busy    out  capture/conversion in progress
//   Sseg    out  [6:0] segments {g,f,e,d,c,b,a}, active-low, registered
//   An      out  [3:0] digit enables, active-low, bit 0 rightmost, registered
//
// Build option
//   ALU_DISP_ERR_BLINK_EN  blink the error pattern using an 8-bit counter
//                          that advances once per digit slot.
//
// state | meaning
// IDLE  | waiting for Init; display shows last completed result
// CONV  | one shift-add-3 iteration per clock, W iterations in total
// DONE  | publish BCD digits and error flag to the display registers

module alu_result_display #(
  parameter int W   = 6,
  parameter int DIV = 50000
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         Init,
  input  logic [W-1:0] Result,
  input  logic         Error,
  output logic         Busy,
  output logic [6:0]   Sseg,
  output logic [3:0]   An
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = $clog2(W + 1);
  localparam logic [CW-1:0] REF_LAST  = CW'(DIV - 1);
  localparam logic [IW-1:0] ITER_INIT = IW'(W);

  localparam logic [3:0] SYM_E     = 4'd10;
  localparam logic [3:0] SYM_R     = 4'd11;
  localparam logic [3:0] SYM_DASH  = 4'd12;
  localparam logic [3:0] SYM_BLANK = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [W-1:0]  r_shift;
  logic [11:0]   r_bcd;
  logic [IW-1:0] r_iter;
  logic          r_err_cap;
  logic [3:0]    r_hund;
  logic [3:0]    r_tens;
  logic [3:0]    r_units;
  logic          r_err_disp;
  logic [CW-1:0] r_refresh;
  logic [1:0]    r_digit;
  logic [3:0]    r_an;
  logic [6:0]    r_sseg;

  logic          w_busy;
  logic [11:0]   w_bcd_adj;
  logic [W+11:0] w_cat;
  logic          w_slot_end;
  logic [3:0]    w_sym;
  logic [6:0]    w_seg;
  logic          w_blank;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] sym);
    case (sym)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      SYM_E:   return 7'b0000110;
      SYM_R:   return 7'b0101111;
      SYM_DASH: return 7'b0111111;
      default: return 7'b1111111;
    endcase
  endfunction

  // ---------------- conversion FSM ----------------
  always_ff @(posedge Clock) begin
    if (!Reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (Init) w_state_nxt = CONV;
      CONV:    if (r_iter == IW'(1)) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_busy = (r_state != IDLE);

  // Double-dabble step: correct every nibble first, then shift {bcd, shift}.
  always_comb begin
    w_bcd_adj = {add3(r_bcd[11:8]), add3(r_bcd[7:4]), add3(r_bcd[3:0])};
    w_cat     = {w_bcd_adj, r_shift} << 1;
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_shift    <= '0;
      r_bcd      <= '0;
      r_iter     <= '0;
      r_err_cap  <= 1'b0;
      r_hund     <= '0;
      r_tens     <= '0;
      r_units    <= '0;
      r_err_disp <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (Init) begin
            r_shift   <= Result;
            r_err_cap <= Error;
            r_bcd     <= '0;
            r_iter    <= ITER_INIT;
          end
        end
        CONV: begin
          r_bcd   <= w_cat[W+11:W];
          r_shift <= w_cat[W-1:0];
          r_iter  <= r_iter - 1'b1;
        end
        DONE: begin
          r_hund     <= r_bcd[11:8];
          r_tens     <= r_bcd[7:4];
          r_units    <= r_bcd[3:0];
          r_err_disp <= r_err_cap;
        end
        default: ;
      endcase
    end
  end

  // ---------------- display scan ----------------
  assign w_slot_end = (r_refresh == REF_LAST);

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_refresh <= '0;
      r_digit   <= 2'd0;
    end else if (w_slot_end) begin
      r_refresh <= '0;
      r_digit   <= r_digit + 2'd1;
    end else begin
      r_refresh <= r_refresh + 1'b1;
    end
  end

`ifdef ALU_DISP_ERR_BLINK_EN
  logic [7:0] r_blink;

  always_ff @(posedge Clock) begin
    if (!Reset)          r_blink <= '0;
    else if (w_slot_end) r_blink <= r_blink + 8'd1;
  end

  assign w_blank = r_err_disp & r_blink[7];
`else
  assign w_blank = 1'b0;
`endif

  always_comb begin
    w_sym = SYM_BLANK;
    if (r_err_disp) begin
      case (r_digit)
        2'd0:    w_sym = SYM_R;
        2'd1:    w_sym = SYM_R;
        2'd2:    w_sym = SYM_E;
        default: w_sym = SYM_BLANK;
      endcase
    end else begin
      case (r_digit)
        2'd0:    w_sym = r_units;
        2'd1:    w_sym = r_tens;
        2'd2:    w_sym = r_hund;
        default: w_sym = w_busy ? SYM_DASH : SYM_BLANK;
      endcase
    end
    w_seg = w_blank ? 7'b1111111 : seg_decode(w_sym);
  end

  // Outputs follow the digit index by one clock.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_an   <= 4'b1111;
      r_sseg <= 7'b1111111;
    end else begin
      r_an   <= ~(4'b0001 << r_digit);
      r_sseg <= w_seg;
    end
  end

  assign Busy = w_busy;
  assign Sseg = r_sseg;
  assign An   = r_an;

endmodule

// File: tb/tb_alu_result_display.sv
`timescale 1ns/1ps
module tb_alu_result_display;

  localparam int DIV = 4;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic       Reset;
  logic       init6, err6, busy6;
  logic [5:0] res6;
  logic [6:0] sseg6;
  logic [3:0] an6;
  logic       init9, err9, busy9;
  logic [8:0] res9;
  logic [6:0] sseg9;
  logic [3:0] an9;

  alu_result_display #(.W(6), .DIV(DIV)) u_dut6 (
    .Clock(Clock), .Reset(Reset), .Init(init6), .Result(res6), .Error(err6),
    .Busy(busy6), .Sseg(sseg6), .An(an6)
  );

  alu_result_display #(.W(9), .DIV(DIV)) u_dut9 (
    .Clock(Clock), .Reset(Reset), .Init(init9), .Result(res9), .Error(err9),
    .Busy(busy9), .Sseg(sseg9), .An(an9)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: edges since reset release, plus per-DUT shown value,
  // in-flight capture and remaining busy clocks.
  int m_j;
  int m_left[2];
  int m_val[2];
  int m_err[2];
  int m_pval[2];
  int m_perr[2];

  function automatic int width_of(int d);
    return (d == 0) ? 6 : 9;
  endfunction

  // Symbols: 0..9 digits, 10=E, 11=r, 12=dash, 13=blank
  function automatic int seg_of(int sym);
    case (sym)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      10: return 7'b0000110;
      11: return 7'b0101111;
      12: return 7'b0111111;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic int digit_sym(int d, int pos);
    if (m_err[d] != 0) begin
      if (pos == 2) return 10;
      if (pos == 3) return 13;
      return 11;
    end
    case (pos)
      0: return m_val[d] % 10;
      1: return (m_val[d] / 10) % 10;
      2: return m_val[d] / 100;
      default: return (m_left[d] > 0) ? 12 : 13;
    endcase
  endfunction

  task automatic step();
    int e_an[2];
    int e_seg[2];
    int pos;
    int in_init[2];
    int in_res[2];
    int in_err[2];
    in_init[0] = int'(init6); in_res[0] = int'(res6); in_err[0] = int'(err6);
    in_init[1] = int'(init9); in_res[1] = int'(res9); in_err[1] = int'(err9);
    for (int d = 0; d < 2; d++) begin
      if (!Reset) begin
        e_an[d]  = 15;
        e_seg[d] = 7'h7f;
      end else begin
        pos      = (m_j / DIV) % 4;
        e_an[d]  = 15 & ~(1 << pos);
        e_seg[d] = seg_of(digit_sym(d, pos));
`ifdef ALU_DISP_ERR_BLINK_EN
        if (m_err[d] != 0 && ((m_j / DIV) / 128) % 2 == 1) e_seg[d] = 7'h7f;
`endif
      end
    end
    if (!Reset) begin
      m_j = 0;
      for (int d = 0; d < 2; d++) begin
        m_left[d] = 0; m_val[d] = 0; m_err[d] = 0;
      end
    end else begin
      m_j++;
      for (int d = 0; d < 2; d++) begin
        if (m_left[d] == 0) begin
          if (in_init[d] != 0) begin
            m_left[d] = width_of(d) + 1;
            m_pval[d] = in_res[d];
            m_perr[d] = in_err[d];
          end
        end else begin
          m_left[d]--;
          if (m_left[d] == 0) begin
            m_val[d] = m_pval[d];
            m_err[d] = m_perr[d];
          end
        end
      end
    end
    @(posedge Clock);
    #1;
    check_eq("an6",   int'(an6),   e_an[0]);
    check_eq("sseg6", int'(sseg6), e_seg[0]);
    check_eq("busy6", int'(busy6), (m_left[0] > 0) ? 1 : 0);
    check_eq("an9",   int'(an9),   e_an[1]);
    check_eq("sseg9", int'(sseg9), e_seg[1]);
    check_eq("busy9", int'(busy9), (m_left[1] > 0) ? 1 : 0);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic pulse6(input int v, input int e);
    init6 = 1'b1; res6 = 6'(v); err6 = e[0];
    step();
    init6 = 1'b0;
  endtask

  task automatic pulse9(input int v, input int e);
    init9 = 1'b1; res9 = 9'(v); err9 = e[0];
    step();
    init9 = 1'b0;
  endtask

  initial begin
    m_j = 0;
    for (int d = 0; d < 2; d++) begin
      m_left[d] = 0; m_val[d] = 0; m_err[d] = 0; m_pval[d] = 0; m_perr[d] = 0;
    end
    Reset = 1'b0;
    init6 = 1'b0; res6 = '0; err6 = 1'b0;
    init9 = 1'b0; res9 = '0; err9 = 1'b0;

    idle(3);
    Reset = 1'b1;
    idle(20);

    pulse6(45, 0);
    pulse9(511, 0);
    idle(30);

    pulse6(63, 0);
    idle(30);

    pulse6(12, 1);
    idle(3);
    pulse6(7, 0);
    idle(30);
    pulse6(7, 0);
    idle(30);

    // Abort a conversion in flight at its third iteration.
    init6 = 1'b1; res6 = 6'd33; err6 = 1'b0;
    init9 = 1'b1; res9 = 9'd33; err9 = 1'b0;
    step();
    init6 = 1'b0; init9 = 1'b0;
    idle(2);
    Reset = 1'b0;
    idle(2);
    Reset = 1'b1;
    idle(20);

    // Hold an error display across a full blink period.
    pulse6(12, 1);
    pulse9(300, 1);
    idle(1100);

    // Random traffic, including Init while busy and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      init6 = ($urandom_range(0, 15) == 0);
      res6  = 6'($urandom);
      err6  = ($urandom_range(0, 3) == 0);
      init9 = ($urandom_range(0, 15) == 0);
      res9  = 9'($urandom);
      err9  = ($urandom_range(0, 3) == 0);
      Reset = ($urandom_range(0, 199) != 0);
      step();
    end
    Reset = 1'b1;
    init6 = 1'b0; init9 = 1'b0;
    idle(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
